led_sequencer: RTL
==================

Name: led_sequencer

Overview:
- Parametrised successor to the fixed 8-LED board driver: drives N_LEDS outputs from an internal pattern register.
- The pattern advances on a prescaled step tick in one of four modes: static, binary count, rotate, bounce.
- Outputs are gated by a global PWM brightness control.
- Sits directly on the board LED pins; mode, pattern and brightness come from switches or a host register block.

Parameters:
- N_LEDS, 8, number of LED outputs (>=2)
- DIV, 12000000, clocks per step tick (>=2); gives 1 Hz at 12 MHz
- PWM_BITS, 4, brightness and PWM counter width (>=1)

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- mode  input  2  0 static, 1 count, 2 rotate-left, 3 bounce
- pattern  input  N_LEDS  value copied into the state register on load
- load  input  1  single-cycle strobe: state <= pattern
- brightness  input  PWM_BITS  duty control; 0 = off, all-ones = fully on
- leds  output  N_LEDS  registered LED drive, active-high
- step  output  1  registered one-cycle pulse, high in the cycle after the state advances

Behaviour:
- Reset (rst=1 at a clk edge):
  - state = 1 (LSB lit), dir = left
  - prescaler = 0, pwm_cnt = 0
  - leds = 0, step = 0
  - rst overrides load and all other inputs.
- Prescaler:
  - Counts 0..DIV-1 and wraps.
  - Internal adv = 1 in the cycle prescaler == DIV-1, so adv fires every DIV cycles.
  - First adv after reset occurs at cycle DIV-1 (cycles counted 0 onward from reset release).
- load:
  - state <= pattern and prescaler <= 0 in the same edge.
  - load has priority over adv: if both occur in the same cycle, the load wins, there is no advance, and step stays 0.
  - dir is unchanged by load.
- State advance, applied on adv according to mode as sampled that cycle:
  - mode 0: state holds.
  - mode 1: state <= state + 1, modulo 2^N_LEDS (all-ones wraps to 0).
  - mode 2: rotate left by 1; the MSB wraps into the LSB.
  - mode 3 bounce, dir = left:
    - state[N_LEDS-1]=1 -> dir <= right and state <= state >> 1
    - otherwise -> state <= state << 1
  - mode 3 bounce, dir = right:
    - state[0]=1 -> dir <= left and state <= state << 1
    - otherwise -> state <= state >> 1
  - Shifts in modes 2 and 3 are logical with zero fill.
  - A zero state stays zero in modes 2 and 3.
  - Multi-bit patterns bounce as a block.
  - dir is held in modes 0-2; entering mode 3 continues with the current dir.
- Mode change:
  - Takes effect at the next adv.
  - No reset of state or prescaler.
- step = adv & ~load, registered (one-cycle latency).
- PWM:
  - pwm_cnt is a free-running PWM_BITS counter that wraps.
  - pwm_on = (pwm_cnt < brightness) | (brightness == all-ones).
  - Duty is brightness / 2^PWM_BITS, except all-ones, which gives 100%.
- leds <= state & {N_LEDS{pwm_on}}, registered.
  - The next state is visible on leds one cycle after the edge that updates state.
- Inputs are sampled synchronously each cycle; no handshake beyond the load strobe.

Test Plan:
- Use N_LEDS=8, DIV=4, PWM_BITS=2, brightness=3 unless stated otherwise.
- Reset/static: hold rst 3 cycles, then mode=0 -> leds=0 during reset, leds=8'h01 afterwards. step pulses every 4 cycles with leds constant at 8'h01.
- Count wrap: load pattern=8'hFE, mode=1 -> after successive steps leds show 8'hFF, then 8'h00, then 8'h01.
- Rotate: load 8'h81, mode=2 -> 8'h03, then 8'h06. Load 8'h00 -> stays 8'h00 across 3 steps.
- Bounce: reset, mode=3 -> 01,02,04,...,80, then 40,20,...,01, then 02. Each step occurs exactly 4 clocks apart.
- Load/adv collision: assert load with pattern=8'h55 in the adv cycle -> no step pulse, leds=8'h55 one cycle later, next step 4 cycles after the load.
- PWM duty: pattern=8'hFF, mode=0:
  - brightness=1 -> leds=8'hFF 1 of every 4 cycles
  - brightness=2 -> 2 of every 4 cycles
  - brightness=0 -> always 0
  - brightness=3 -> always 8'hFF
  - Mid-run rst -> leds=0 next cycle and state returns to 8'h01.

Source files
------------

// File: rtl/led_sequencer.sv
// ---------------------------------------------------------------------------
// led_sequencer
//
// Drives N_LEDS board LED pins from an internal pattern register. The pattern
// advances once per prescaled step tick in one of four modes (static, binary
// count, rotate-left, bounce). A global PWM brightness control gates all
// outputs.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   mode        0 static, 1 count, 2 rotate-left, 3 bounce
//   pattern     value copied into the state register when load is high
//   load        single-cycle strobe: state <= pattern, prescaler restarts
//   brightness  PWM duty control; 0 = off, all-ones = fully on
//   leds        registered LED drive, active-high
//   step        registered one-cycle pulse, high the cycle after an advance
// ---------------------------------------------------------------------------
module led_sequencer #(
   parameter int N_LEDS   = 8,
   parameter int DIV      = 12000000,
   parameter int PWM_BITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          mode,
   input  logic [N_LEDS-1:0]   pattern,
   input  logic                load,
   input  logic [PWM_BITS-1:0] brightness,
   output logic [N_LEDS-1:0]   leds,
   output logic                step
);

   localparam int PRE_W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

   localparam logic [1:0] MODE_STATIC = 2'd0;
   localparam logic [1:0] MODE_COUNT  = 2'd1;
   localparam logic [1:0] MODE_ROTATE = 2'd2;
   localparam logic [1:0] MODE_BOUNCE = 2'd3;

   // Bounce direction: the only piece of sequencing state beyond the pattern.
   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_t;

   logic [N_LEDS-1:0]   state_q, state_d;
   dir_t                dir_q, dir_d;
   logic [PRE_W-1:0]    pre_q, pre_d;
   logic [PWM_BITS-1:0] pwm_q;
   logic                adv;
   logic                pwm_on;

   // ---- next-state: prescaler, pattern advance, bounce direction ----
   always_comb begin
      adv     = (pre_q == PRE_LAST);
      pwm_on  = (pwm_q < brightness) || (&brightness);
      state_d = state_q;
      dir_d   = dir_q;
      pre_d   = adv ? '0 : pre_q + PRE_W'(1);

      if (load) begin
         // A load coinciding with a tick swallows that tick entirely.
         state_d = pattern;
         pre_d   = '0;
      end else if (adv) begin
         case (mode)
            MODE_STATIC: state_d = state_q;
            MODE_COUNT:  state_d = state_q + N_LEDS'(1);
            MODE_ROTATE: state_d = {state_q[N_LEDS-2:0], state_q[N_LEDS-1]};
            MODE_BOUNCE: begin
               // Turn around when the leading edge of the block hits the end;
               // the turnaround step already moves one position back.
               if (dir_q == DIR_LEFT) begin
                  if (state_q[N_LEDS-1]) begin
                     dir_d   = DIR_RIGHT;
                     state_d = state_q >> 1;
                  end else begin
                     state_d = state_q << 1;
                  end
               end else begin
                  if (state_q[0]) begin
                     dir_d   = DIR_LEFT;
                     state_d = state_q << 1;
                  end else begin
                     state_d = state_q >> 1;
                  end
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   // ---- registers: state, direction, counters, LED drive, step pulse ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= N_LEDS'(1);
         dir_q   <= DIR_LEFT;
         pre_q   <= '0;
         pwm_q   <= '0;
         leds    <= '0;
         step    <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         pre_q   <= pre_d;
         pwm_q   <= pwm_q + PWM_BITS'(1);
         // leds follow the current state, so a new state shows one edge later.
         leds    <= state_q & {N_LEDS{pwm_on}};
         step    <= adv & ~load;
      end
   end

endmodule
